demux1a2_dosbits: RTL and testbench

Registered 1-to-2 demultiplexer for 2-bit data words with per-lane valid/ready handshake. It sits at the receiving end of the 2:1 two-bit mux link and splits the single muxed stream back into lane 0 and lane 1. In alternating mode it steers consecutive accepted words to lane 0, lane 1, lane 0, and so on. In external mode it steers by a selector input. Each lane holds its word in a one-entry output register until the downstream consumer takes it.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_lane_reg.sv | 44 ++++
 rtl/demux1a2_dosbits.sv | 77 +++++++
 tb/tb_demux1a2_dosbits.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 two-bit demultiplexer slice.
package demux_pkg;

  localparam int unsigned WIDTH = 2;

  localparam bit LANE0 = 1'b0;
  localparam bit LANE1 = 1'b1;

  localparam bit MODE_EXT = 1'b0;
  localparam bit MODE_ALT = 1'b1;

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry output register for a demux lane: holds a word until the consumer takes it.
module demux_lane_reg #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             load,
  input  logic             ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             can_accept,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign can_accept = !valid_q || ready;
  assign valid      = valid_q;
  assign data       = data_q;

  // A load wins over a drain so a full lane can be refilled in the cycle it empties.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/demux1a2_dosbits.sv
// Registered 1-to-2 demux: steers each accepted word to lane 0 or lane 1 by an
// alternating internal selector or by the external selector input.
module demux1a2_dosbits #(
  parameter int unsigned WIDTH    = demux_pkg::WIDTH,
  parameter bit          MODE_ALT = demux_pkg::MODE_ALT
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             selector,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out0,
  output logic             valid_out1,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  input  logic             ready0,
  input  logic             ready1
);

  import demux_pkg::*;

  logic sel_q, sel_d;
  logic sel_eff;
  logic can_accept0, can_accept1;
  logic accept;
  logic load0, load1;

  assign sel_eff  = (MODE_ALT == demux_pkg::MODE_EXT) ? selector : sel_q;
  assign ready_in = (sel_eff == LANE1) ? can_accept1 : can_accept0;
  assign accept   = valid_in && ready_in;
  assign load0    = accept && (sel_eff == LANE0);
  assign load1    = accept && (sel_eff == LANE1);

  // Toggles in both modes; only the alternating mode looks at it.
  always_comb begin
    sel_d = sel_q;
    if (accept) begin
      sel_d = !sel_q;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
    end
  end

  demux_lane_reg #(
    .WIDTH (WIDTH)
  ) u_lane0 (
    .clk        (clk),
    .reset_L    (reset_L),
    .load       (load0),
    .ready      (ready0),
    .data_in    (data_in),
    .can_accept (can_accept0),
    .valid      (valid_out0),
    .data       (data_out0)
  );

  demux_lane_reg #(
    .WIDTH (WIDTH)
  ) u_lane1 (
    .clk        (clk),
    .reset_L    (reset_L),
    .load       (load1),
    .ready      (ready1),
    .data_in    (data_in),
    .can_accept (can_accept1),
    .valid      (valid_out1),
    .data       (data_out1)
  );

endmodule

// File: tb/tb_demux1a2_dosbits.sv
// Self-checking bench: alternating and external-mode instances share stimulus and are
// compared every cycle against a lane-array reference model.
module tb_demux1a2_dosbits;

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic       selector = 1'b0;
  logic       valid_in = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic [1:0] rdy = 2'b11;

  logic       rin_a, v0_a, v1_a, rin_e, v0_e, v1_e;
  logic [1:0] d0_a, d1_a, d0_e, d1_e;
  logic [6:0] obs_a, obs_e;

  int checks = 0;
  int failures = 0;

  // Model: index 1 = alternating instance, 0 = external instance.
  logic       mv [2][2];
  logic [1:0] md [2][2];
  logic       alt_turn;

  always #5 clk = !clk;

  assign obs_a = {rin_a, v0_a, v1_a, d0_a, d1_a};
  assign obs_e = {rin_e, v0_e, v1_e, d0_e, d1_e};

  demux1a2_dosbits #(.WIDTH(2), .MODE_ALT(1'b1)) dut_a (
    .clk(clk), .reset_L(reset_L), .selector(selector), .valid_in(valid_in),
    .data_in(data_in), .ready_in(rin_a), .valid_out0(v0_a), .valid_out1(v1_a),
    .data_out0(d0_a), .data_out1(d1_a), .ready0(rdy[0]), .ready1(rdy[1])
  );

  demux1a2_dosbits #(.WIDTH(2), .MODE_ALT(1'b0)) dut_e (
    .clk(clk), .reset_L(reset_L), .selector(selector), .valid_in(valid_in),
    .data_in(data_in), .ready_in(rin_e), .valid_out0(v0_e), .valid_out1(v1_e),
    .data_out0(d0_e), .data_out1(d1_e), .ready0(rdy[0]), .ready1(rdy[1])
  );

  function automatic logic [6:0] exp_vec(int m);
    logic s;
    s = (m == 1) ? alt_turn : selector;
    return {(!mv[m][s] || rdy[s]), mv[m][0], mv[m][1], md[m][0], md[m][1]};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 2; k++) begin
        mv[m][k] = 1'b0;
        md[m][k] = 2'b00;
      end
    end
    alt_turn = 1'b0;
  endtask

  // Advance one rising edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    logic s, acc;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      s   = (m == 1) ? alt_turn : selector;
      acc = valid_in && (!mv[m][s] || rdy[s]);
      for (int k = 0; k < 2; k++) begin
        if (acc && (int'(s) == k)) begin
          mv[m][k] = 1'b1;
          md[m][k] = data_in;
        end else if (mv[m][k] && rdy[k]) begin
          mv[m][k] = 1'b0;
        end
      end
      if (m == 1 && acc) alt_turn = !alt_turn;
    end
    #1;
  endtask

  task automatic test_reset();
    valid_in = 1'b0;
    rdy      = 2'b11;
    reset_L  = 1'b0;
    model_reset();
    #7;
    checks++;
    if (obs_a !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_alt got=%b exp=%b", obs_a, 7'b1000000);
    end
    checks++;
    if (obs_e !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ext got=%b exp=%b", obs_e, 7'b1000000);
    end
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    checks++;
    if (obs_a !== exp_vec(1)) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", obs_a, exp_vec(1));
    end
  endtask

  task automatic test_alt_basic();
    logic [1:0] words [4];
    words[0] = 2'b01; words[1] = 2'b10; words[2] = 2'b11; words[3] = 2'b00;
    rdy      = 2'b11;
    selector = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      data_in  = words[i];
      #1;
      checks++;
      if (rin_a !== 1'b1) begin
        failures++;
        $display("FAIL alt_basic_ready word=%0d got=%b exp=1", i, rin_a);
      end
      tick();
      checks++;
      if ((i % 2 == 0) ? ({v0_a, d0_a} !== {1'b1, words[i]})
                       : ({v1_a, d1_a} !== {1'b1, words[i]})) begin
        failures++;
        $display("FAIL alt_basic_lane word=%0d got v0=%b d0=%b v1=%b d1=%b exp=%b", i,
                 v0_a, d0_a, v1_a, d1_a, words[i]);
      end
      checks++;
      if (obs_e !== exp_vec(0)) begin
        failures++;
        $display("FAIL alt_basic_ext got=%b exp=%b", obs_e, exp_vec(0));
      end
    end
    valid_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stall();
    rdy      = 2'b10;
    selector = 1'b0;
    valid_in = 1'b1;
    data_in  = 2'b01;
    tick();
    data_in  = 2'b10;
    tick();
    data_in  = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({rin_a, v0_a, d0_a} !== {1'b0, 1'b1, 2'b01}) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got rin=%b v0=%b d0=%b exp rin=0 v0=1 d0=01", i,
                 rin_a, v0_a, d0_a);
      end
      tick();
    end
    rdy = 2'b11;
    #1;
    checks++;
    if (rin_a !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready got=%b exp=1", rin_a);
    end
    tick();
    checks++;
    if ({v0_a, d0_a} !== {1'b1, 2'b11}) begin
      failures++;
      $display("FAIL stall_release_load got v0=%b d0=%b exp v0=1 d0=11", v0_a, d0_a);
    end
    checks++;
    if (obs_e !== exp_vec(0)) begin
      failures++;
      $display("FAIL stall_ext got=%b exp=%b", obs_e, exp_vec(0));
    end
    valid_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_ext();
    logic [1:0] words [3];
    words[0] = 2'b11; words[1] = 2'b10; words[2] = 2'b01;
    rdy      = 2'b10;
    selector = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in  = words[i];
      tick();
      checks++;
      if ({v0_e, v1_e, d1_e} !== {1'b0, 1'b1, words[i]}) begin
        failures++;
        $display("FAIL ext_lane1 word=%0d got v0=%b v1=%b d1=%b exp v0=0 v1=1 d1=%b", i,
                 v0_e, v1_e, d1_e, words[i]);
      end
      checks++;
      if (obs_a !== exp_vec(1)) begin
        failures++;
        $display("FAIL ext_alt_model got=%b exp=%b", obs_a, exp_vec(1));
      end
    end
    valid_in = 1'b0;
    rdy      = 2'b11;
    tick();
    tick();
  endtask

  task automatic test_drain_load();
    rdy      = 2'b00;
    selector = 1'b0;
    valid_in = 1'b1;
    data_in  = 2'b10;
    tick();
    rdy     = 2'b01;
    data_in = 2'b01;
    #1;
    checks++;
    if ({rin_e, v0_e, d0_e} !== {1'b1, 1'b1, 2'b10}) begin
      failures++;
      $display("FAIL drain_load_pre got rin=%b v0=%b d0=%b exp rin=1 v0=1 d0=10",
               rin_e, v0_e, d0_e);
    end
    tick();
    checks++;
    if ({v0_e, d0_e} !== {1'b1, 2'b01}) begin
      failures++;
      $display("FAIL drain_load got v0=%b d0=%b exp v0=1 d0=01", v0_e, d0_e);
    end
    checks++;
    if (obs_a !== exp_vec(1)) begin
      failures++;
      $display("FAIL drain_load_alt got=%b exp=%b", obs_a, exp_vec(1));
    end
    valid_in = 1'b0;
    rdy      = 2'b11;
    tick();
  endtask

  task automatic test_mid_reset();
    rdy      = 2'b00;
    valid_in = 1'b1;
    selector = 1'b0;
    data_in  = 2'b11;
    tick();
    selector = 1'b1;
    data_in  = 2'b01;
    tick();
    valid_in = 1'b0;
    checks++;
    if ({v0_e, v1_e, d0_e, d1_e} !== 6'b11_11_01) begin
      failures++;
      $display("FAIL mid_reset_full got=%b exp=111101", {v0_e, v1_e, d0_e, d1_e});
    end
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_a[5:0] !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset_alt got=%b exp=000000", obs_a[5:0]);
    end
    checks++;
    if (obs_e[5:0] !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset_ext got=%b exp=000000", obs_e[5:0]);
    end
    #2;
    reset_L  = 1'b1;
    rdy      = 2'b11;
    selector = 1'b0;
    valid_in = 1'b1;
    data_in  = 2'b10;
    tick();
    checks++;
    if ({v0_a, v1_a, d0_a} !== {1'b1, 1'b0, 2'b10}) begin
      failures++;
      $display("FAIL mid_reset_first got v0=%b v1=%b d0=%b exp v0=1 v1=0 d0=10",
               v0_a, v1_a, d0_a);
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_idle();
    // Alternating turn now points at lane 1.
    rdy      = 2'b01;
    valid_in = 1'b1;
    data_in  = 2'b11;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in  = 2'($urandom);
      selector = 1'($urandom);
      tick();
      checks++;
      if ({v1_a, d1_a} !== 3'b1_11 || $isunknown(obs_a) || $isunknown(obs_e)) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got v1=%b d1=%b a=%b e=%b exp v1=1 d1=11",
                 i, v1_a, d1_a, obs_a, obs_e);
      end
    end
    rdy = 2'b11;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_in = 1'($urandom);
      data_in  = 2'($urandom);
      selector = 1'($urandom);
      rdy      = 2'($urandom_range(3, 0));
      #1;
      checks++;
      if (obs_a !== exp_vec(1) || obs_e !== exp_vec(0)) begin
        failures++;
        $display("FAIL random cyc=%0d got a=%b e=%b exp a=%b e=%b", i, obs_a, obs_e,
                 exp_vec(1), exp_vec(0));
      end
      tick();
    end
    valid_in = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alt_basic();
    test_stall();
    test_ext();
    test_drain_load();
    test_mid_reset();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
